// File: rtl/shift_issue_stage.sv
// ID-to-EX issue stage for the shift datapath: decodes the shift opcode at accept
// and buffers decoded operands in a two-entry skid buffer with valid/ready on both sides.
module shift_issue_stage #(
  parameter int DW  = 32,
  parameter int SAW = 5,
  parameter int RW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_op,
  input  logic [SAW-1:0] in_shamt,
  input  logic [DW-1:0]  in_rs,
  input  logic [DW-1:0]  in_rt,
  input  logic [RW-1:0]  in_rd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_d,
  output logic [SAW-1:0] out_sa,
  output logic           out_right,
  output logic           out_arith,
  output logic [RW-1:0]  out_rd,
  output logic           out_badop,
  output logic [1:0]     occ
);

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [SAW-1:0] sa;
    logic           right;
    logic           arith;
    logic [RW-1:0]  rd;
    logic           badop;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Reserved op 01 falls out as sll (right = 0, arith = 0) and is flagged.
  function automatic entry_t decode(input logic [2:0]     op,
                                    input logic [SAW-1:0] shamt,
                                    input logic [SAW-1:0] rs_amt,
                                    input logic [DW-1:0]  rt,
                                    input logic [RW-1:0]  rd);
    entry_t e;
    e.d     = rt;
    e.sa    = op[2] ? rs_amt : shamt;
    e.right = op[1];
    e.arith = op[1] & op[0];
    e.rd    = rd;
    e.badop = (op[1:0] == 2'b01);
    return e;
  endfunction

  state_e state_q;
  entry_t head_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   in_ready_q;

  logic   accept_s;
  logic   issue_s;
  entry_t new_s;
  logic   unused_rs_s;

  // Handshake qualification and decode of the incoming instruction.
  always_comb begin
    accept_s = in_valid & in_ready_q;
    issue_s  = out_valid_q & out_ready;
    new_s    = decode(in_op, in_shamt, in_rs[SAW-1:0], in_rt, in_rd);
  end

  assign unused_rs_s = ^in_rs[DW-1:SAW];

  // Buffer FSM; head_q always holds the oldest entry so out_* are plain register taps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept_s) begin
            head_q      <= new_s;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ONE: begin
          case ({accept_s, issue_s})
            2'b10: begin
              skid_q     <= new_s;
              state_q    <= FULL;
              in_ready_q <= 1'b0;
            end
            2'b01: begin
              state_q     <= EMPTY;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end
            2'b11: begin
              head_q     <= new_s;
              in_ready_q <= 1'b1;
            end
            default: begin
              in_ready_q <= 1'b1;
            end
          endcase
        end
        FULL: begin
          if (issue_s) begin
            head_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_d     = head_q.d;
  assign out_sa    = head_q.sa;
  assign out_right = head_q.right;
  assign out_arith = head_q.arith;
  assign out_rd    = head_q.rd;
  assign out_badop = head_q.badop;
  assign occ       = state_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage; expected values are hand-computed.
module tb_shift_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_d;
  logic [4:0]  out_sa;
  logic        out_right;
  logic        out_arith;
  logic [4:0]  out_rd;
  logic        out_badop;
  logic [1:0]  occ;

  int tests_run = 0;
  int tests_failed = 0;

  shift_issue_stage #(.DW(32), .SAW(5), .RW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
    .out_sa(out_sa), .out_right(out_right), .out_arith(out_arith),
    .out_rd(out_rd), .out_badop(out_badop), .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    in_valid = v;
    in_op    = op;
    in_shamt = sh;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
  endtask

  logic [31:0] shifted;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    #3;
    check_eq("rst_out_valid", out_valid, 64'd0);
    check_eq("rst_occ", occ, 64'd0);
    check_eq("rst_in_ready", in_ready, 64'd0);
    check_eq("rst_out_d", out_d, 64'd0);
    #4 rst = 1'b0;
    tick();
    check_eq("post_rst_in_ready", in_ready, 64'd1);

    // sll passthrough
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 5'd4, 32'h0, 32'h0000_00F1, 5'd5);
    tick();
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    check_eq("sll_valid", out_valid, 64'd1);
    check_eq("sll_d", out_d, 64'h0000_00F1);
    check_eq("sll_sa", out_sa, 64'd4);
    check_eq("sll_right", out_right, 64'd0);
    check_eq("sll_arith", out_arith, 64'd0);
    check_eq("sll_rd", out_rd, 64'd5);
    check_eq("sll_occ", occ, 64'd1);
    tick();
    check_eq("sll_drain_occ", occ, 64'd0);

    // srav decode: amount from rs[4:0], shamt ignored
    drive(1'b1, 3'b111, 5'd7, 32'hFFFF_FF23, 32'h8000_0000, 5'd9);
    tick();
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    check_eq("srav_sa", out_sa, 64'd3);
    check_eq("srav_right", out_right, 64'd1);
    check_eq("srav_arith", out_arith, 64'd1);
    check_eq("srav_badop", out_badop, 64'd0);
    shifted = $unsigned($signed(out_d) >>> out_sa);
    check_eq("srav_shifter", shifted, 64'hF000_0000);
    tick();
    check_eq("srav_drain_occ", occ, 64'd0);

    // back-pressure: A, B accepted, C held
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 5'd1, 32'h0, 32'hAAAA_0001, 5'd1);
    tick();
    drive(1'b1, 3'b010, 5'd2, 32'h0, 32'hBBBB_0002, 5'd2);
    tick();
    drive(1'b1, 3'b010, 5'd3, 32'h0, 32'hCCCC_0003, 5'd3);
    check_eq("bp_occ_full", occ, 64'd2);
    check_eq("bp_in_ready", in_ready, 64'd0);
    check_eq("bp_head_a", out_d, 64'hAAAA_0001);
    tick();
    check_eq("bp_stable_d", out_d, 64'hAAAA_0001);
    check_eq("bp_stable_sa", out_sa, 64'd1);
    check_eq("bp_stable_occ", occ, 64'd2);
    out_ready = 1'b1;
    tick();
    check_eq("bp_issue_b", out_d, 64'hBBBB_0002);
    check_eq("bp_issue_b_sa", out_sa, 64'd2);
    check_eq("bp_occ_one", occ, 64'd1);
    tick();
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    check_eq("bp_issue_c", out_d, 64'hCCCC_0003);
    check_eq("bp_issue_c_rd", out_rd, 64'd3);
    tick();
    check_eq("bp_drain_occ", occ, 64'd0);
    check_eq("bp_drain_valid", out_valid, 64'd0);

    // streaming: accept and issue together at occ = 1
    drive(1'b1, 3'b000, 5'd0, 32'h0, 32'h5000_0000, 5'd0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 3'b000, i[4:0], 32'h0, 32'h5000_0000 + i, i[4:0]);
      tick();
      check_eq($sformatf("stream_d_%0d", i), out_d, 64'h5000_0000 + i);
      check_eq($sformatf("stream_occ_%0d", i), occ, 64'd1);
    end
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    tick();
    check_eq("stream_drain_occ", occ, 64'd0);

    // flush at occ = 2 with a same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 5'd1, 32'h0, 32'h1111_0001, 5'd1);
    tick();
    drive(1'b1, 3'b000, 5'd2, 32'h0, 32'h2222_0002, 5'd2);
    tick();
    check_eq("fl_pre_occ", occ, 64'd2);
    flush = 1'b1;
    drive(1'b1, 3'b000, 5'd3, 32'h0, 32'hDDDD_0004, 5'd4);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    check_eq("fl_occ", occ, 64'd0);
    check_eq("fl_out_valid", out_valid, 64'd0);
    check_eq("fl_in_ready", in_ready, 64'd1);
    tick();
    check_eq("fl_no_ghost", out_valid, 64'd0);

    // flush while empty discards the same-cycle accept
    flush = 1'b1;
    drive(1'b1, 3'b000, 5'd3, 32'h0, 32'hEEEE_0005, 5'd5);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    check_eq("fl_empty_occ", occ, 64'd0);
    check_eq("fl_empty_valid", out_valid, 64'd0);

    // async reset mid-operation
    drive(1'b1, 3'b000, 5'd1, 32'h0, 32'h3333_0001, 5'd1);
    tick();
    drive(1'b1, 3'b000, 5'd2, 32'h0, 32'h3333_0002, 5'd2);
    tick();
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    check_eq("ar_pre_occ", occ, 64'd2);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_out_valid", out_valid, 64'd0);
    check_eq("ar_occ", occ, 64'd0);
    #2 rst = 1'b0;
    tick();
    check_eq("ar_in_ready", in_ready, 64'd1);

    // reserved op 001 decodes as sll with badop flagged
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 5'd9, 32'h0000_001F, 32'h0000_0F0F, 5'd7);
    tick();
    drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd0);
    check_eq("bad_badop", out_badop, 64'd1);
    check_eq("bad_right", out_right, 64'd0);
    check_eq("bad_arith", out_arith, 64'd0);
    check_eq("bad_sa", out_sa, 64'd9);
    check_eq("bad_valid", out_valid, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Registered ID-to-EX issue stage for the shift datapath in the pipelined MIPS core.
- Decodes the ID-stage shift opcode into shifter controls: data, shift amount, right, arith.
- Holds operands in a 2-entry skid buffer with valid/ready handshakes on both sides, so the barrel shifter downstream sees stable operands under EX back-pressure.
- Supports a synchronous pipeline flush for branch/exception squash.

Parameters:
- DW, 32, operand data width; the shifter consumes 32 bits.
- SAW, 5, shift-amount width; equals log2(DW).
- RW, 5, destination register-number width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  ID presents a shift instruction.
- in_ready  output  1  stage can accept this cycle.
- in_op  input  3  [2] = variable amount (sllv/srlv/srav); [1:0]: 00 = sll, 10 = srl, 11 = sra, 01 = reserved.
- in_shamt  input  SAW  instruction shamt field.
- in_rs  input  DW  rs operand; bits [SAW-1:0] give the variable amount.
- in_rt  input  DW  rt operand; the data to be shifted.
- in_rd  input  RW  destination register.
- out_valid  output  1  EX-side entry valid.
- out_ready  input  1  EX consumes this cycle.
- out_d  output  DW  data to shifter.
- out_sa  output  SAW  shift amount to shifter.
- out_right  output  1  1 = right shift.
- out_arith  output  1  1 = arithmetic (sign-fill).
- out_rd  output  RW  destination register.
- out_badop  output  1  entry carried reserved op 01.
- occ  output  2  buffered entry count, 0..2.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, occ = 0, both entries invalid. in_ready = 1 from the first clock edge after rst deasserts.
- Decode, done at accept and stored decoded:
  - sa = in_op[2] ? in_rs[SAW-1:0] : in_shamt.
  - right = in_op[1]; arith = in_op[1] & in_op[0].
  - op 01 decodes as sll (right = 0, arith = 0) with badop = 1.
- Accept: a transfer occurs when in_valid & in_ready. Drive in_ready = (occ != 2), taken from registered state only, with no combinational path from out_ready.
- Issue: a transfer occurs when out_valid & out_ready. out_* always present the oldest entry; out_valid = (occ != 0).
- Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N when the buffer was empty.
- State transitions on accept/issue (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL; issue only -> EMPTY; accept and issue together -> ONE, with the new entry becoming the head.
  - FULL: issue -> ONE, with the skid entry promoting to head. Accept is impossible because in_ready = 0.
- Order: strict FIFO; entries never reorder or duplicate.
- Stability: while out_valid & ~out_ready, out_* hold constant.
- Flush: at the edge where flush = 1, occ -> 0 and both entries are cleared.
  - A same-cycle accept is discarded.
  - A same-cycle issue still counts as consumed by EX.
  - The data registers may retain stale values; only valid bits are cleared.
- rst asserted mid-operation: entries are lost immediately; no partial state survives.
- occ is always exactly 0, 1 or 2.

Test Plan:
- sll passthrough: in_op = 000, shamt = 4, rt = 0x0000_00F1, out_ready = 1 -> next cycle out_d = 0x0000_00F1, out_sa = 4, out_right = 0, out_arith = 0, out_valid = 1.
- srav decode: in_op = 111, rs = 0xFFFF_FF23, shamt = 7, rt = 0x8000_0000 -> out_sa = 3 (rs[4:0]), right = 1, arith = 1; a shifter fed from these outputs gives 0xF000_0000.
- Back-pressure: out_ready = 0 and push 3 instructions A, B, C -> A and B accepted, occ = 2, in_ready = 0, C held. Raise out_ready -> issue order A, B, C with no loss; out_* stable while stalled.
- Simultaneous accept and issue at occ = 1 over 10 streaming cycles -> occ stays 1, throughput 1 per cycle, order preserved.
- Flush at occ = 2 with in_valid = 1 in the same cycle -> next cycle occ = 0, out_valid = 0, in_ready = 1; the flushed-cycle input never appears at the output.
- Async reset: assert rst between clock edges while occ = 2 -> out_valid = 0 and occ = 0 immediately; reserved op 001 after reset -> out_badop = 1, out_right = 0.
